multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL declare parameter WIDTH, default 32, operand magnitude width.
REQ-002 SHALL declare clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL declare rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL declare mul_rst  input  1  synchronous soft clear from calculator control; returns block to IDLE.
REQ-005 SHALL declare mul_start  input  1  start request, honoured in IDLE or DONE only.
REQ-006 SHALL declare inputa_sign, inputb_sign  input  1 each  operand signs (1 = negative).
REQ-007 SHALL declare unsign_inputa, unsign_inputb  input  WIDTH each  operand magnitudes.
REQ-008 SHALL declare mul_busy  output  1  high while in BUSY.
REQ-009 SHALL declare mul_done  output  1  high while in DONE.
REQ-010 SHALL declare mul_result  output  2*WIDTH  product magnitude.
REQ-011 SHALL declare mul_sign  output  1  product sign.
REQ-012 SHALL declare mul_ovf  output  1  product magnitude does not fit in WIDTH bits.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE or DONE with mul_start=1 SHALL capture both magnitudes and signs, clear accumulator and bit counter, and enter BUSY.
REQ-015 Mid-operation operand changes SHALL NOT affect the result, since operands are captured at start.
REQ-016 SHALL perform radix-2 shift-add: each BUSY cycle adds the shifted multiplicand to the 2*WIDTH accumulator when the current multiplier LSB is 1, then shifts the multiplier right.
REQ-017 SHALL use a bit counter of $clog2(WIDTH)+1 bits, incremented each BUSY cycle.
REQ-018 SHALL leave BUSY for DONE after exactly WIDTH BUSY cycles; no early termination on zero operands.
REQ-019 Latency SHALL be fixed: start sampled at edge E0 gives mul_done=1 after edge E(WIDTH), i.e. edge 32 for WIDTH=32.
REQ-020 In DONE, mul_result, mul_sign and mul_ovf SHALL hold stable until the next honoured mul_start or a reset.
REQ-021 mul_start while BUSY SHALL be ignored without disturbing the operation.
REQ-022 mul_start while in DONE SHALL restart the multiplier.
REQ-023 mul_sign SHALL equal inputa_sign XOR inputb_sign of the captured operands, forced 0 when the product is zero.
REQ-024 mul_ovf SHALL equal the OR of mul_result[2*WIDTH-1:WIDTH].
REQ-025 mul_result, mul_sign and mul_ovf SHALL be registered outputs, valid when mul_done=1.
REQ-026 The accumulator SHALL be 2*WIDTH bits wide and SHALL NOT wrap, because the product of two WIDTH-bit values always fits.
REQ-027 mul_rst and mul_start asserted together SHALL resolve to mul_rst: end state IDLE, no operation started.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL enter IDLE.
REQ-029 On rst=1, all outputs (mul_busy, mul_done, mul_result, mul_sign, mul_ovf) SHALL be 0.
REQ-030 On rst=1, the counter, accumulator and captured operands SHALL be 0.
REQ-031 rst and mul_rst asserted mid-BUSY SHALL abort the operation; mul_done SHALL NOT assert for the aborted operation.
REQ-032 rst SHALL take priority over mul_rst and mul_start.
REQ-033 mul_rst SHALL clear the same state as rst.

Structure
REQ-034 The shared calculator package SHALL hold the WIDTH default, the counter width constant, and the FSM state encoding.
REQ-035 State registers SHALL be built from the team's enable flip-flop primitive dflip_en; no other sub-module.

Verification
REQ-036 Basic signed product: a=7 sign 1, b=6 sign 0, start -> mul_done high at edge 32, mul_result=42, mul_sign=1, mul_ovf=0, mul_busy high edges 1-31 inclusive.
REQ-037 Maximum operands: a=b=0xFFFFFFFF, both signs 1 -> mul_result=0xFFFFFFFE00000001, mul_sign=0, mul_ovf=1.
REQ-038 Zero product sign: a=0 sign 1, b=5 sign 0 -> mul_result=0, mul_sign=0, mul_ovf=0, latency still 32.
REQ-039 Abort mid-run: start a=3, b=3, then mul_rst at BUSY cycle 10 -> IDLE next edge, all outputs 0, mul_done never asserts.
REQ-040 Start handling: mul_start pulsed at BUSY cycle 5 with new operands -> ignored, result 9 for a=b=3; then mul_start in DONE with a=0x10000, b=0x10000 -> restart, result 0x100000000, mul_ovf=1.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared calculator definitions: default operand width, counter width and FSM encoding.
package multiplier_pkg;

  localparam int unsigned MulWidth    = 32;
  localparam int unsigned MulCntWidth = $clog2(MulWidth) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/multiplier_if.sv
// Control/operand/result bundle between calculator control and the multiplier.
interface multiplier_if #(
  parameter int unsigned WIDTH = 32
);

  logic               mul_rst;
  logic               mul_start;
  logic               inputa_sign;
  logic               inputb_sign;
  logic [WIDTH-1:0]   unsign_inputa;
  logic [WIDTH-1:0]   unsign_inputb;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_result;
  logic               mul_sign;
  logic               mul_ovf;

  modport master (
    output mul_rst, mul_start, inputa_sign, inputb_sign, unsign_inputa, unsign_inputb,
    input  mul_busy, mul_done, mul_result, mul_sign, mul_ovf
  );

  modport slave (
    input  mul_rst, mul_start, inputa_sign, inputb_sign, unsign_inputa, unsign_inputb,
    output mul_busy, mul_done, mul_result, mul_sign, mul_ovf
  );

endinterface

// File: rtl/dflip_en.sv
// Enable flip-flop primitive with synchronous active-high clear.
module dflip_en #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add sign/magnitude multiplier, fixed WIDTH-cycle latency.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MulWidth
) (
  input logic         clk,
  input logic         rst,
  multiplier_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned AccW = 2 * WIDTH;

  // Soft clear from control behaves exactly like the hard reset.
  logic clr;
  assign clr = rst | bus.mul_rst;

  mul_state_e      state_q, state_d;
  logic [1:0]      state_raw;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            sa_q, sb_q;
  logic            sign_q, sign_d;
  logic            ovf_q, ovf_d;

  logic load, busy, last;
  logic en_dp, en_flags;

  assign state_q = mul_state_e'(state_raw);
  assign busy    = (state_q == StBusy);
  assign load    = bus.mul_start & ((state_q == StIdle) | (state_q == StDone));
  assign last    = busy & (cnt_q == CntW'(WIDTH - 1));
  assign en_dp    = load | busy;
  assign en_flags = load | last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StBusy;
      StBusy:  if (last) state_d = StDone;
      StDone:  if (load) state_d = StBusy;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q + CntW'(1);
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    sign_d   = (sa_q ^ sb_q) & (|acc_d);
    ovf_d    = |acc_d[AccW-1:WIDTH];
    if (load) begin
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, bus.unsign_inputa};
      mplier_d = bus.unsign_inputb;
      sign_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  dflip_en #(.Width(2)) u_state (
    .clk_i(clk), .rst_i(clr), .en_i(1'b1), .d_i(state_d), .q_o(state_raw)
  );
  dflip_en #(.Width(CntW)) u_cnt (
    .clk_i(clk), .rst_i(clr), .en_i(en_dp), .d_i(cnt_d), .q_o(cnt_q)
  );
  dflip_en #(.Width(AccW)) u_acc (
    .clk_i(clk), .rst_i(clr), .en_i(en_dp), .d_i(acc_d), .q_o(acc_q)
  );
  dflip_en #(.Width(AccW)) u_mcand (
    .clk_i(clk), .rst_i(clr), .en_i(en_dp), .d_i(mcand_d), .q_o(mcand_q)
  );
  dflip_en #(.Width(WIDTH)) u_mplier (
    .clk_i(clk), .rst_i(clr), .en_i(en_dp), .d_i(mplier_d), .q_o(mplier_q)
  );
  dflip_en #(.Width(2)) u_signs (
    .clk_i(clk), .rst_i(clr), .en_i(load),
    .d_i({bus.inputa_sign, bus.inputb_sign}), .q_o({sa_q, sb_q})
  );
  dflip_en #(.Width(2)) u_flags (
    .clk_i(clk), .rst_i(clr), .en_i(en_flags),
    .d_i({sign_d, ovf_d}), .q_o({sign_q, ovf_q})
  );

  assign bus.mul_busy   = busy;
  assign bus.mul_done   = (state_q == StDone);
  assign bus.mul_result = acc_q;
  assign bus.mul_sign   = sign_q;
  assign bus.mul_ovf    = ovf_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the shift-add multiplier: latency, products, signs, aborts, restarts.
module tb_multiplier;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multiplier_if #(.WIDTH(W)) bus ();

  multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic sa,
                          input logic [W-1:0] b, input logic sb);
    bus.unsign_inputa = a;
    bus.inputa_sign   = sa;
    bus.unsign_inputb = b;
    bus.inputb_sign   = sb;
    bus.mul_start     = 1'b1;
    tick();
    bus.mul_start     = 1'b0;
  endtask

  // Counts edges until mul_done, bounded; busy must be high on every edge before done.
  task automatic wait_done(input int base, output int lat, output int busy_bad);
    lat      = base;
    busy_bad = 0;
    while (bus.mul_done !== 1'b1 && lat < 100) begin
      if (bus.mul_busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic check_outputs(input string tag, input logic busy, input logic done,
                               input logic [63:0] res, input logic sgn, input logic ovf);
    check({tag, "_busy"},   64'(bus.mul_busy),  64'(busy));
    check({tag, "_done"},   64'(bus.mul_done),  64'(done));
    check({tag, "_result"}, bus.mul_result,     res);
    check({tag, "_sign"},   64'(bus.mul_sign),  64'(sgn));
    check({tag, "_ovf"},    64'(bus.mul_ovf),   64'(ovf));
  endtask

  initial begin
    int lat;
    int bad;
    int done_seen;
    checks   = 0;
    failures = 0;

    rst               = 1'b1;
    bus.mul_rst       = 1'b0;
    bus.mul_start     = 1'b0;
    bus.inputa_sign   = 1'b0;
    bus.inputb_sign   = 1'b0;
    bus.unsign_inputa = '0;
    bus.unsign_inputb = '0;
    tick();
    tick();
    check_outputs("reset", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_outputs("idle", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);

    // 7 (neg) * 6 (pos) = -42
    start_op(32'd7, 1'b1, 32'd6, 1'b0);
    check("basic_busy_e0", 64'(bus.mul_busy), 64'd1);
    wait_done(0, lat, bad);
    check("basic_latency", 64'(lat), 64'd32);
    check("basic_busy_run", 64'(bad), 64'd0);
    check_outputs("basic", 1'b0, 1'b1, 64'd42, 1'b1, 1'b0);

    // Result holds in DONE while inputs wander.
    bus.unsign_inputa = 32'h1234;
    bus.inputb_sign   = 1'b1;
    repeat (3) tick();
    check_outputs("hold", 1'b0, 1'b1, 64'd42, 1'b1, 1'b0);

    // Max operands, restart straight from DONE.
    start_op(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, lat, bad);
    check("max_latency", 64'(lat), 64'd32);
    check_outputs("max", 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);

    // Zero product forces positive sign; no early exit.
    start_op(32'd0, 1'b1, 32'd5, 1'b0);
    wait_done(0, lat, bad);
    check("zero_latency", 64'(lat), 64'd32);
    check_outputs("zero", 1'b0, 1'b1, 64'd0, 1'b0, 1'b0);

    // Soft clear mid-run.
    start_op(32'd3, 1'b0, 32'd3, 1'b1);
    repeat (10) tick();
    check("abort_pre_result", bus.mul_result, 64'd9);
    bus.mul_rst = 1'b1;
    tick();
    bus.mul_rst = 1'b0;
    check_outputs("abort", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.mul_done === 1'b1 || bus.mul_busy === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // mul_rst beats mul_start.
    bus.mul_rst       = 1'b1;
    bus.mul_start     = 1'b1;
    tick();
    bus.mul_rst       = 1'b0;
    bus.mul_start     = 1'b0;
    tick();
    check_outputs("rst_vs_start", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);

    // Hard reset mid-run, asserted together with a start request.
    start_op(32'd5, 1'b1, 32'd5, 1'b0);
    repeat (4) tick();
    rst           = 1'b1;
    bus.mul_start = 1'b1;
    tick();
    rst           = 1'b0;
    bus.mul_start = 1'b0;
    check_outputs("hard_abort", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);

    // Start while BUSY is ignored; operand changes don't leak in.
    start_op(32'd3, 1'b0, 32'd3, 1'b0);
    repeat (5) tick();
    start_op(32'd5, 1'b1, 32'd7, 1'b0);
    wait_done(6, lat, bad);
    check("ignore_latency", 64'(lat), 64'd32);
    check("ignore_busy_run", 64'(bad), 64'd0);
    check_outputs("ignore", 1'b0, 1'b1, 64'd9, 1'b0, 1'b0);

    // Start in DONE restarts.
    start_op(32'h0001_0000, 1'b0, 32'h0001_0000, 1'b1);
    check("restart_busy", 64'(bus.mul_busy), 64'd1);
    wait_done(0, lat, bad);
    check("restart_latency", 64'(lat), 64'd32);
    check_outputs("restart", 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
